// File: rtl/flag_req_sender_if.sv
// Handshake-side signal bundle for flag_req_sender: event input, async ack,
// request toggle and status. master = the sender, slave = its environment.
interface flag_req_sender_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 flag_in;
  logic                 ack_toggle_in;
  logic                 clear_err;
  logic                 req_toggle_out;
  logic                 busy;
  logic [CNT_WIDTH-1:0] pending_cnt;
  logic                 overflow;
  logic                 timeout_err;

  modport master (
    input  flag_in, ack_toggle_in, clear_err,
    output req_toggle_out, busy, pending_cnt, overflow, timeout_err
  );

  modport slave (
    output flag_in, ack_toggle_in, clear_err,
    input  req_toggle_out, busy, pending_cnt, overflow, timeout_err
  );
endinterface

// File: rtl/flag_req_sender.sv
// Toggle req/ack handshake initiator with pending-event counter and replay.
// Optional ack timeout is compiled in with `define FLAG_REQ_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no request outstanding; launches on flag_in or queued events
// WAIT_ACK | req toggled, waiting for synchronized ack to match it
module flag_req_sender #(
  parameter int SYNC_STAGES    = 3,
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  flag_req_sender_if.master bus
);

  if (SYNC_STAGES < 2) begin : gBadSyncStages
    $error("flag_req_sender: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : gBadTimeout
    $error("flag_req_sender: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] ackSync;
  logic                   ackCur;
  logic                   reqTgl;
  logic [CNT_WIDTH-1:0]   pendCnt;
  logic                   ovf;
  logic                   toErr;

  logic ackMatch;
  logic pendNz;
  logic pendFull;
  logic dropEvt;
  logic toExpire;

  assign ackCur   = ackSync[SYNC_STAGES-1];
  assign ackMatch = (ackCur == reqTgl);
  assign pendNz   = (pendCnt != '0);
  assign pendFull = (pendCnt == CNT_MAX);
  // Only WAIT_ACK can drop: an IDLE launch always consumes as much as it enqueues.
  assign dropEvt  = (state == WAIT_ACK) && bus.flag_in && pendFull;

`ifdef FLAG_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] toCnt;

  // Expiry on the TIMEOUT_CYCLES-th WAIT_ACK cycle; a match in that cycle wins.
  assign toExpire = (state == WAIT_ACK) && !ackMatch && (toCnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt <= '0;
      toErr <= 1'b0;
    end else begin
      if ((state == WAIT_ACK) && !ackMatch && !toExpire) begin
        toCnt <= toCnt + TO_W'(1);
      end else begin
        toCnt <= '0;
      end
      toErr <= toExpire | (toErr & ~bus.clear_err);
    end
  end
`else
  assign toExpire = 1'b0;
  assign toErr    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ackSync <= '0;
      reqTgl  <= 1'b0;
      pendCnt <= '0;
      ovf     <= 1'b0;
    end else begin
      ackSync <= {ackSync[SYNC_STAGES-2:0], bus.ack_toggle_in};
      ovf     <= dropEvt | (ovf & ~bus.clear_err);
      case (state)
        IDLE: begin
          if (bus.flag_in || pendNz) begin
            reqTgl <= ~reqTgl;
            state  <= WAIT_ACK;
            if (pendNz && !bus.flag_in) begin
              pendCnt <= pendCnt - CNT_ONE;
            end
          end
        end
        WAIT_ACK: begin
          if (bus.flag_in && !pendFull) begin
            pendCnt <= pendCnt + CNT_ONE;
          end
          if (ackMatch) begin
            state <= IDLE;
          end else if (toExpire) begin
            // Re-align req with the far end so the next launch starts clean.
            reqTgl <= ackCur;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_toggle_out = reqTgl;
  assign bus.busy           = (state == WAIT_ACK);
  assign bus.pending_cnt    = pendCnt;
  assign bus.overflow       = ovf;
  assign bus.timeout_err    = toErr;

endmodule

// File: tb/tb_flag_req_sender.sv
// Directed bench for flag_req_sender: far-end ack model plus a scoreboard of
// expected req levels, one entry pushed per launch, popped on each req toggle.
module tb_flag_req_sender;

  localparam int SYNC_STAGES    = 3;
  localparam int CNT_WIDTH      = 4;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int ACK_DELAY      = 5;

  logic clk;
  logic rst_n = 1'b1;

  flag_req_sender_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  flag_req_sender #(
    .SYNC_STAGES    (SYNC_STAGES),
    .CNT_WIDTH      (CNT_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   asrtCnt = 0;
  int   failCnt = 0;
  int   toggleCnt = 0;
  logic sb[$];
  logic expLevel = 1'b0;
  logic holdAck = 1'b0;
  logic prevReq = 1'b0;
  logic expPop;
  int   ackDly = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asrtCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushLaunch();
    expLevel = ~expLevel;
    sb.push_back(expLevel);
  endtask

  task automatic pulseFlag(input int n);
    bus.flag_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      pushLaunch();
      tick();
    end
    bus.flag_in = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(bus.busy == 1'b0 && bus.pending_cnt == '0) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_reached"}, (n < budget), 1'b1);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    sb.delete();
    expLevel = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Far end: returns ack ACK_DELAY cycles after seeing a new req level.
  initial begin
    bus.ack_toggle_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.ack_toggle_in = 1'b0;
        ackDly = 0;
      end else if (!holdAck && bus.req_toggle_out != bus.ack_toggle_in) begin
        ackDly++;
        if (ackDly == ACK_DELAY) begin
          bus.ack_toggle_in = bus.req_toggle_out;
          ackDly = 0;
        end
      end else begin
        ackDly = 0;
      end
    end
  end

  // Every req edge must match the next scoreboard entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prevReq = bus.req_toggle_out;
      end else if (bus.req_toggle_out !== prevReq) begin
        prevReq = bus.req_toggle_out;
        toggleCnt++;
        check("toggle_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          expPop = sb.pop_front();
          check("req_toggle_level", bus.req_toggle_out, expPop);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busyCycles;
    int t0;
    int n;
    bus.flag_in   = 1'b0;
    bus.clear_err = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_req", bus.req_toggle_out, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_pending", bus.pending_cnt, 0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_req", bus.req_toggle_out, 1'b0);

    // 1: single event, busy spans ack delay plus synchronizer depth
    bus.flag_in = 1'b1;
    pushLaunch();
    tick();
    bus.flag_in = 1'b0;
    check("t1_req_rise", bus.req_toggle_out, 1'b1);
    busyCycles = bus.busy ? 1 : 0;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
      if (bus.busy) busyCycles++;
    end
    check("t1_busy_cycles", busyCycles, ACK_DELAY + SYNC_STAGES);
    check("t1_pending", bus.pending_cnt, 0);
    applyReset();

    // 2: burst of four events
    t0 = toggleCnt;
    pulseFlag(4);
    check("t2_pending_peak", bus.pending_cnt, 3);
    check("t2_busy", bus.busy, 1'b1);
    waitIdle("t2", 500);
    check("t2_toggle_count", toggleCnt - t0, 4);
    check("t2_final_req", bus.req_toggle_out, 1'b0);

`ifndef FLAG_REQ_TIMEOUT_EN
    // 3: saturation, drop, clear, and set-beats-clear
    holdAck = 1'b1;
    t0 = toggleCnt;
    bus.flag_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) pushLaunch();
      tick();
    end
    bus.flag_in = 1'b0;
    check("t3_pending_sat", bus.pending_cnt, 15);
    check("t3_overflow_set", bus.overflow, 1'b1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    check("t3_overflow_cleared", bus.overflow, 1'b0);
    bus.clear_err = 1'b1;
    bus.flag_in = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    bus.flag_in = 1'b0;
    check("t3_overflow_set_wins", bus.overflow, 1'b1);
    check("t3_pending_no_wrap", bus.pending_cnt, 15);
    repeat (40) tick();
    check("t3_still_waiting", bus.busy, 1'b1);
    check("t3_no_timeout", bus.timeout_err, 1'b0);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    holdAck = 1'b0;
    waitIdle("t3", 2000);
    check("t3_toggle_count", toggleCnt - t0, 16);
`endif

    // 4: flag with pending events in IDLE, then flag on the completion cycle
    holdAck = 1'b1;
    pulseFlag(3);
    holdAck = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check("t4_idle_pending", bus.pending_cnt, 2);
    bus.flag_in = 1'b1;
    pushLaunch();
    tick();
    bus.flag_in = 1'b0;
    check("t4_launch_busy", bus.busy, 1'b1);
    check("t4_pending_kept", bus.pending_cnt, 2);
    repeat (ACK_DELAY + SYNC_STAGES - 1) tick();
    check("t4_busy_before_done", bus.busy, 1'b1);
    bus.flag_in = 1'b1;
    pushLaunch();
    tick();
    bus.flag_in = 1'b0;
    check("t4_done_idle", bus.busy, 1'b0);
    check("t4_pending_inc", bus.pending_cnt, 3);
    waitIdle("t4", 500);

    // 5: async reset in WAIT_ACK with five queued
    holdAck = 1'b1;
    pulseFlag(6);
    check("t5_pending", bus.pending_cnt, 5);
    check("t5_busy", bus.busy, 1'b1);
    #3;
    rst_n = 1'b0;
    sb.delete();
    expLevel = 1'b0;
    #1;
    check("t5_async_req", bus.req_toggle_out, 1'b0);
    check("t5_async_busy", bus.busy, 1'b0);
    check("t5_async_pending", bus.pending_cnt, 0);
    check("t5_async_overflow", bus.overflow, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    holdAck = 1'b0;
    t0 = toggleCnt;
    repeat (10) tick();
    check("t5_no_toggle", toggleCnt - t0, 0);
    check("t5_req_quiet", bus.req_toggle_out, 1'b0);
    check("t5_busy_quiet", bus.busy, 1'b0);

`ifdef FLAG_REQ_TIMEOUT_EN
    // 6: no ack returned, timeout realigns req and pending events replay
    holdAck = 1'b1;
    bus.flag_in = 1'b1;
    pushLaunch();
    tick();
    bus.flag_in = 1'b0;
    busyCycles = bus.busy ? 1 : 0;
    pushLaunch();
    bus.flag_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pushLaunch();
      tick();
      if (bus.busy) busyCycles++;
    end
    bus.flag_in = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
      if (bus.busy) busyCycles++;
    end
    check("t6_busy_cycles", busyCycles, TIMEOUT_CYCLES);
    check("t6_timeout_err", bus.timeout_err, 1'b1);
    check("t6_busy_low", bus.busy, 1'b0);
    check("t6_req_eq_ack", bus.req_toggle_out, bus.ack_toggle_in);
    check("t6_pending_kept", bus.pending_cnt, 2);
    holdAck = 1'b0;
    waitIdle("t6", 500);
    check("t6_err_sticky", bus.timeout_err, 1'b1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    check("t6_err_cleared", bus.timeout_err, 1'b0);
`else
    check("t6_timeout_tied", bus.timeout_err, 1'b0);
`endif

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asrtCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/flag_req_sender.md
Name: flag_req_sender

Overview:
- Source-side initiator of a toggle request/acknowledge handshake.
- Converts single-cycle event pulses into level toggles on req_toggle_out.
- Holds each request until the far end returns a matching toggle on ack_toggle_in, which arrives asynchronously and is synchronized internally.
- Events that arrive while a handshake is outstanding are counted and replayed in order, so no event is lost up to counter capacity.

Parameters:
SYNC_STAGES, 3, flops in the ack synchronizer chain (legal minimum 2)
CNT_WIDTH, 4, width of pending-event counter; capacity 2^CNT_WIDTH-1
TIMEOUT_CYCLES, 1024, WAIT_ACK cycles before timeout (used only with FLAG_REQ_TIMEOUT_EN)

Ports:
clk  in  1  single clock; all state on posedge
rst_n  in  1  asynchronous, active-low reset
flag_in  in  1  event pulse, one event per high cycle, synchronous to clk
ack_toggle_in  in  1  far-end acknowledge toggle, asynchronous to clk
clear_err  in  1  clears sticky overflow and timeout_err
req_toggle_out  out  1  request toggle level, registered
busy  out  1  high while in WAIT_ACK
pending_cnt  out  CNT_WIDTH  queued events not yet launched
overflow  out  1  sticky: an event was dropped at saturation
timeout_err  out  1  sticky: ack timeout occurred (constant 0 without macro)

Behaviour:
- Reset: all outputs and internal state are 0, including the synchronizer chain, state, and timeout counter.
- After reset the state is IDLE.
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Ack synchronizer: each cycle, ack_toggle_in shifts through SYNC_STAGES flops. ack_cur is the last stage. No logic reads the earlier stages.
- State IDLE:
  - Launch condition: flag_in=1 or pending_cnt!=0.
  - On launch: invert req_toggle_out and go to WAIT_ACK. The new level is visible the cycle after the launch.
  - If pending_cnt!=0 and flag_in=0: the launch consumes one pending event, so pending_cnt-1.
  - If pending_cnt!=0 and flag_in=1: consume one and enqueue one, so pending_cnt is unchanged.
  - If pending_cnt==0 and flag_in=1: launch directly; pending_cnt stays 0.
- State WAIT_ACK:
  - Completion: when ack_cur==req_toggle_out, go to IDLE next cycle.
  - Back-to-back launches are therefore separated by at least one IDLE cycle.
  - flag_in=1 in WAIT_ACK enqueues one event, including the completion cycle.
- Counter saturation: at pending_cnt=2^CNT_WIDTH-1, a further event is dropped and overflow sets. The count never wraps.
- clear_err=1 clears overflow and timeout_err. If a set event occurs in the same cycle, set wins.
- busy is exactly (state==WAIT_ACK).
- Order: events are launched strictly one per handshake. Counts are preserved; event identity is not carried.
- Reset mid-operation: pending events are discarded and the outstanding request is abandoned.
  - The far end must be reset in the same reset domain event so that both toggles restart at 0.
  - If it is not, the first launch may complete spuriously; that is a system-level error and is not detected here.
- The far-end receiver recovers the event as an edge of the synchronized req level. One ack toggle is returned per received req toggle.

Optional Feature:
FLAG_REQ_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT_ACK; it resets to 0 on entry and on exit.
  - When the counter reaches TIMEOUT_CYCLES without completion:
    - timeout_err sets (sticky).
    - req_toggle_out is forced equal to ack_cur.
    - State goes to IDLE next cycle; pending_cnt is kept.
  - Completion in the same cycle as expiry takes priority, and no error is raised.
- Undefined: no counter exists, timeout_err is tied to 0, and WAIT_ACK waits indefinitely.

Test Plan:
1. Single event: flag_in=1 for one cycle, with ack looped back by a model delaying 5 cycles then toggling.
   - Required: req_toggle_out 0->1 the next cycle; busy=1 until 3 cycles after ack toggles (SYNC_STAGES=3); then busy=0 and pending_cnt=0.
2. Burst: flag_in=1 for 4 consecutive cycles from IDLE.
   - Required: pending_cnt reaches 3.
   - Required: exactly 4 req toggles over time; final req_toggle_out=0; pending_cnt returns to 0.
3. Saturation: hold the ack model, send 17 events (CNT_WIDTH=4).
   - Required: after the first launch, pending_cnt=15 and overflow=1.
   - Required: clear_err pulse clears overflow, and a concurrent extra event keeps overflow=1.
4. Simultaneous: in IDLE with pending_cnt=2, pulse flag_in.
   - Required: launch occurs and pending_cnt stays 2.
   - Required: flag_in on the completion cycle raises pending_cnt by 1.
5. Async reset: assert rst_n=0 mid WAIT_ACK with pending_cnt=5.
   - Required: all outputs are 0 immediately, without waiting for a clk edge.
   - Required: after release, no toggle occurs without a new flag_in.
6. Timeout (macro defined, TIMEOUT_CYCLES=16): no ack returned.
   - Required: timeout_err=1 after 16 WAIT_ACK cycles, req_toggle_out=ack_cur, busy=0.
   - Required: pending events then launch normally.
